countdown_timer_ctrl: RTL

Programmable countdown timer controller built around a loadable down counter and a tick prescaler. It sequences the counter through load, run, pause and expire states, and raises a one-cycle `done` on terminal count. An optional auto-reload mode turns it into a periodic event source. It sits between a control/host interface and any logic that needs timed events.

---
 rtl/countdown_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 25 ++
 rtl/countdown_timer_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer controller.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PRESCALE-1 divider; wrap flags the edge on which a count step occurs.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  assign wrap = en && !clr && (pre_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pre_q <= '0;
    else if (clr)      pre_q <= '0;
    else if (en)       pre_q <= wrap ? '0 : pre_q + PW'(1);
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer: load/run/pause/expire sequencing with one-cycle tick and done pulses.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q, reload_q;
  logic             tick_q, done_q;
  logic             pre_clr, pre_en, step;

  // A resume from PAUSED keeps the partial prescale phase; fresh starts do not.
  assign pre_clr = load ||
                   (start && (state_q == ST_IDLE || state_q == ST_EXPIRED));
  assign pre_en  = (state_q == ST_RUN) && !load && !pause;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .wrap (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '1;
      reload_q <= '1;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (load) begin
        count_q  <= load_val;
        reload_q <= load_val;
        state_q  <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_PAUSED: if (start) state_q <= ST_RUN;
          ST_EXPIRED: if (start) begin
            count_q <= reload_q;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSED;
            end else if (step) begin
              tick_q <= 1'b1;
              if (count_q == '0) begin
                done_q <= 1'b1;
                if (auto_reload) count_q <= reload_q;
                else             state_q <= ST_EXPIRED;
              end else begin
                count_q <= count_q - WIDTH'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign tick  = tick_q;
  assign done  = done_q;

endmodule
